// File: rtl/sdrc_req_buf.sv
// sdrc_req_buf: request FIFO between the application and the SDRAM request
// generator. Each accepted request gets a rolling transfer ID. The head
// entry is offered on a req/req_ack handshake, so bank-controller
// backpressure never reaches the application directly. Zero-length
// requests are acknowledged, consume no ID, and are dropped with a pulse.
module sdrc_req_buf #(
  parameter int APP_AW = 30,
  parameter int APP_RW = 9,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              app_req,
  input  logic [APP_AW-1:0] app_req_addr,
  input  logic [APP_RW-1:0] app_req_len,
  input  logic              app_req_wr_n,
  input  logic              app_req_wrap,
  output logic              app_req_ack,
  output logic [ID_W-1:0]   app_req_id,
  output logic              req,
  output logic [ID_W-1:0]   req_id,
  output logic [APP_AW-1:0] req_addr,
  output logic [APP_RW-1:0] req_len,
  output logic              req_wr_n,
  output logic              req_wrap,
  input  logic              req_ack,
  output logic [PTR_W:0]    buf_cnt,
  output logic              buf_full,
  output logic              buf_empty,
  output logic              drop_zero
);

  localparam int ENTRY_W = ID_W + APP_AW + APP_RW + 2;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             drop_q, drop_d;

  logic push;
  logic pop;

  // Full is judged on the current count only; a same-cycle pop never makes
  // room for a push, which keeps app_req_ack independent of req_ack.
  assign buf_full    = (cnt_q == FULL_CNT);
  assign buf_empty   = (cnt_q == '0);
  assign buf_cnt     = cnt_q;
  assign app_req_ack = app_req & ~buf_full;
  assign app_req_id  = id_q;
  assign drop_zero   = drop_q;

  assign push = app_req_ack & (|app_req_len);
  assign pop  = req & req_ack;

  // Head entry comes straight from storage; it only moves when rd_ptr does.
  assign req = ~buf_empty;
  assign {req_id, req_addr, req_len, req_wr_n, req_wrap} = mem_q[rd_ptr_q];

  // Next-state for pointers, count, ID counter and the drop pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    drop_d   = app_req_ack & ~(|app_req_len);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      id_d     = id_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {id_q, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap};
    end
  end

endmodule

// File: tb/tb_sdrc_req_buf.sv
// Testbench for sdrc_req_buf: a table of single-cycle vectors followed by
// hand-written sequences for fill/full, ID wrap and mid-operation reset.
module tb_sdrc_req_buf;

  logic        clk;
  logic        reset_n;
  logic        appReq;
  logic [29:0] appReqAddr;
  logic [8:0]  appReqLen;
  logic        appReqWrN;
  logic        appReqWrap;
  logic        appReqAck;
  logic [3:0]  appReqId;
  logic        req;
  logic [3:0]  reqId;
  logic [29:0] reqAddr;
  logic [8:0]  reqLen;
  logic        reqWrN;
  logic        reqWrap;
  logic        reqAck;
  logic [2:0]  bufCnt;
  logic        bufFull;
  logic        bufEmpty;
  logic        dropZero;

  int testCount = 0;
  int failCount = 0;

  sdrc_req_buf dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .app_req      (appReq),
    .app_req_addr (appReqAddr),
    .app_req_len  (appReqLen),
    .app_req_wr_n (appReqWrN),
    .app_req_wrap (appReqWrap),
    .app_req_ack  (appReqAck),
    .app_req_id   (appReqId),
    .req          (req),
    .req_id       (reqId),
    .req_addr     (reqAddr),
    .req_len      (reqLen),
    .req_wr_n     (reqWrN),
    .req_wrap     (reqWrap),
    .req_ack      (reqAck),
    .buf_cnt      (bufCnt),
    .buf_full     (bufFull),
    .buf_empty    (bufEmpty),
    .drop_zero    (dropZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        appReq;
    logic [29:0] addr;
    logic [8:0]  len;
    logic        wrN;
    logic        wrap;
    logic        reqAck;
    logic        expAck;
    logic [3:0]  expAppId;
    logic        expReq;
    logic [3:0]  expReqId;
    logic [29:0] expAddr;
    logic [8:0]  expLen;
    logic        expWrN;
    logic        expWrap;
    logic [2:0]  expCnt;
    logic        expDrop;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic a, input logic [29:0] ad, input logic [8:0] l,
                              input logic w, input logic wp, input logic ra,
                              input logic eAck, input logic [3:0] eId,
                              input logic eReq, input logic [3:0] eRid,
                              input logic [29:0] eAd, input logic [8:0] eL,
                              input logic eW, input logic eWp,
                              input logic [2:0] eCnt, input logic eDrop);
    vec_t v;
    v.appReq = a;      v.addr = ad;       v.len = l;
    v.wrN = w;         v.wrap = wp;       v.reqAck = ra;
    v.expAck = eAck;   v.expAppId = eId;  v.expReq = eReq;
    v.expReqId = eRid; v.expAddr = eAd;   v.expLen = eL;
    v.expWrN = eW;     v.expWrap = eWp;   v.expCnt = eCnt;
    v.expDrop = eDrop;
    return v;
  endfunction

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count-derived flags plus the occupancy bound.
  task automatic checkCount(input string tag, input logic [2:0] expCnt);
    checkOutput({tag, " buf_cnt"}, 32'(bufCnt), 32'(expCnt));
    checkOutput({tag, " buf_full"}, 32'(bufFull), 32'(expCnt == 3'd4));
    checkOutput({tag, " buf_empty"}, 32'(bufEmpty), 32'(expCnt == 3'd0));
    checkOutput({tag, " cnt<=DEPTH"}, 32'(bufCnt <= 3'd4), 32'd1);
  endtask

  task automatic drive(input logic a, input logic [29:0] ad, input logic [8:0] l,
                       input logic w, input logic wp, input logic ra);
    appReq = a; appReqAddr = ad; appReqLen = l;
    appReqWrN = w; appReqWrap = wp; reqAck = ra;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    drive(1'b0, 30'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
  endtask

  // Drive one table vector, compare in the middle of the cycle, then clock.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.appReq, v.addr, v.len, v.wrN, v.wrap, v.reqAck);
    @(negedge clk);
    checkOutput({tag, " app_req_ack"}, 32'(appReqAck), 32'(v.expAck));
    if (v.expAck) checkOutput({tag, " app_req_id"}, 32'(appReqId), 32'(v.expAppId));
    checkOutput({tag, " req"}, 32'(req), 32'(v.expReq));
    if (v.expReq) begin
      checkOutput({tag, " req_id"}, 32'(reqId), 32'(v.expReqId));
      checkOutput({tag, " req_addr"}, 32'(reqAddr), 32'(v.expAddr));
      checkOutput({tag, " req_len"}, 32'(reqLen), 32'(v.expLen));
      checkOutput({tag, " req_wr_n"}, 32'(reqWrN), 32'(v.expWrN));
      checkOutput({tag, " req_wrap"}, 32'(reqWrap), 32'(v.expWrap));
    end
    checkOutput({tag, " drop_zero"}, 32'(dropZero), 32'(v.expDrop));
    checkCount(tag, v.expCnt);
    nextCycle();
  endtask

  initial begin
    // Reset state, single request, zero-length drop, push+pop at count 2,
    // and req_ack while empty.
    vecs[0]  = mk(0, 30'h0,   9'd0,  0, 0, 0,  0, 4'd0,  0, 4'd0, 30'h0,   9'd0,  0, 0,  3'd0, 0);
    vecs[1]  = mk(1, 30'h100, 9'd8,  0, 0, 0,  1, 4'd0,  0, 4'd0, 30'h0,   9'd0,  0, 0,  3'd0, 0);
    vecs[2]  = mk(0, 30'h0,   9'd0,  0, 0, 1,  0, 4'd0,  1, 4'd0, 30'h100, 9'd8,  0, 0,  3'd1, 0);
    vecs[3]  = mk(0, 30'h0,   9'd0,  0, 0, 0,  0, 4'd0,  0, 4'd0, 30'h0,   9'd0,  0, 0,  3'd0, 0);
    vecs[4]  = mk(1, 30'h200, 9'd0,  1, 0, 0,  1, 4'd1,  0, 4'd0, 30'h0,   9'd0,  0, 0,  3'd0, 0);
    vecs[5]  = mk(1, 30'h300, 9'd4,  1, 1, 0,  1, 4'd1,  0, 4'd0, 30'h0,   9'd0,  0, 0,  3'd0, 1);
    vecs[6]  = mk(1, 30'h400, 9'd2,  0, 0, 0,  1, 4'd2,  1, 4'd1, 30'h300, 9'd4,  1, 1,  3'd1, 0);
    vecs[7]  = mk(1, 30'h500, 9'd16, 1, 0, 1,  1, 4'd3,  1, 4'd1, 30'h300, 9'd4,  1, 1,  3'd2, 0);
    vecs[8]  = mk(0, 30'h0,   9'd0,  0, 0, 0,  0, 4'd0,  1, 4'd2, 30'h400, 9'd2,  0, 0,  3'd2, 0);
    vecs[9]  = mk(0, 30'h0,   9'd0,  0, 0, 1,  0, 4'd0,  1, 4'd2, 30'h400, 9'd2,  0, 0,  3'd2, 0);
    vecs[10] = mk(0, 30'h0,   9'd0,  0, 0, 1,  0, 4'd0,  1, 4'd3, 30'h500, 9'd16, 1, 0,  3'd1, 0);
    vecs[11] = mk(0, 30'h0,   9'd0,  0, 0, 1,  0, 4'd0,  0, 4'd0, 30'h0,   9'd0,  0, 0,  3'd0, 0);
    vecs[12] = mk(0, 30'h0,   9'd0,  0, 0, 0,  0, 4'd0,  0, 4'd0, 30'h0,   9'd0,  0, 0,  3'd0, 0);

    resetDut();
    for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

    // Fill with req_ack low: four accepted with IDs 0..3, fifth refused.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 30'h1000 + 30'(i), 9'(i + 1), i[0], 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("fill%0d ack", i), 32'(appReqAck), 32'd1);
      checkOutput($sformatf("fill%0d id", i), 32'(appReqId), 32'(i));
      checkCount($sformatf("fill%0d", i), 3'(i));
      nextCycle();
    end
    drive(1'b1, 30'h1004, 9'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fill4 ack refused", 32'(appReqAck), 32'd0);
    checkCount("fill4", 3'd4);
    nextCycle();
    // Full with simultaneous app_req and req_ack: still refused, count drops.
    drive(1'b1, 30'h1004, 9'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fullpop ack refused", 32'(appReqAck), 32'd0);
    checkOutput("fullpop head id", 32'(reqId), 32'd0);
    checkCount("fullpop", 3'd4);
    nextCycle();
    drive(1'b1, 30'h1004, 9'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("retry ack", 32'(appReqAck), 32'd1);
    checkOutput("retry id", 32'(appReqId), 32'd4);
    checkCount("retry", 3'd3);
    nextCycle();
    // Drain: entries leave in order with their own fields.
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 30'd0, 9'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("drain%0d req", i), 32'(req), 32'd1);
      checkOutput($sformatf("drain%0d id", i), 32'(reqId), 32'(i));
      checkOutput($sformatf("drain%0d addr", i), 32'(reqAddr), 32'h1000 + 32'(i));
      checkOutput($sformatf("drain%0d len", i), 32'(reqLen), 32'(i + 1));
      checkOutput($sformatf("drain%0d wr_n", i), 32'(reqWrN), 32'(i % 2));
      checkCount($sformatf("drain%0d", i), 3'(5 - i));
      nextCycle();
    end
    drive(1'b0, 30'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drained req", 32'(req), 32'd0);
    checkCount("drained", 3'd0);

    // ID wrap with continuous draining: IDs 0..15 then 0.
    resetDut();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 30'(k), 9'd1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("wrap%0d ack", k), 32'(appReqAck), 32'd1);
      checkOutput($sformatf("wrap%0d id", k), 32'(appReqId), 32'(k % 16));
      checkOutput($sformatf("wrap%0d req", k), 32'(req), 32'(k > 0));
      if (k > 0) checkOutput($sformatf("wrap%0d head id", k), 32'(reqId), 32'((k - 1) % 16));
      checkCount($sformatf("wrap%0d", k), 3'(k > 0));
      nextCycle();
    end
    drive(1'b0, 30'd0, 9'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wrap tail id", 32'(reqId), 32'd0);
    checkOutput("wrap tail addr", 32'(reqAddr), 32'd16);
    nextCycle();

    // Mid-operation reset with three entries queued.
    drive(1'b0, 30'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30'h2000 + 30'(i), 9'd3, 1'b0, 1'b0, 1'b0);
      nextCycle();
    end
    drive(1'b0, 30'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkCount("prereset", 3'd3);
    checkOutput("prereset next id", 32'(appReqId), 32'd4);
    nextCycle();
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("postreset req", 32'(req), 32'd0);
    checkOutput("postreset drop", 32'(dropZero), 32'd0);
    checkCount("postreset", 3'd0);
    nextCycle();
    drive(1'b1, 30'h3000, 9'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postreset ack", 32'(appReqAck), 32'd1);
    checkOutput("postreset id", 32'(appReqId), 32'd0);
    nextCycle();
    drive(1'b0, 30'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postreset head addr", 32'(reqAddr), 32'h3000);
    checkCount("postreset push", 3'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
